ext_xbar_rr_arbiter: RTL
========================

EXT_XBAR_RR_ARBITER -- requirements
Module: ext_xbar_rr_arbiter

Interface
REQ-001 SHALL have parameter NMASTER, default 4, number of master ports (one per CGRA column), range 1..16.
REQ-002 SHALL have parameter NSLAVE, default 1, number of slave ports and address rules, range 1..8.
REQ-003 SHALL have parameter ADDR_RULES, default a single rule {idx 0, start 32'hF000_0000, end 32'hF010_0000}, an array of NSLAVE address rules.
REQ-004 SHALL have parameter DECERR_DATA, default 32'hBADA_CCE5, read data returned on decode error.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port m_req_i, input, NMASTER bits: master request.
REQ-008 SHALL have ports m_addr_i (input, NMASTER x 32 bits), m_we_i (input, NMASTER bits), m_be_i (input, NMASTER x 4 bits) and m_wdata_i (input, NMASTER x 32 bits): master request payload.
REQ-009 SHALL have ports m_gnt_o (output, NMASTER bits), m_rvalid_o (output, NMASTER bits), m_rdata_o (output, NMASTER x 32 bits) and m_err_o (output, NMASTER bits): master grant and response.
REQ-010 SHALL have ports s_req_o (output, NSLAVE bits), s_addr_o (output, NSLAVE x 32 bits), s_we_o (output, NSLAVE bits), s_be_o (output, NSLAVE x 4 bits) and s_wdata_o (output, NSLAVE x 32 bits): slave request.
REQ-011 SHALL have ports s_gnt_i (input, NSLAVE bits), s_rvalid_i (input, NSLAVE bits) and s_rdata_i (input, NSLAVE x 32 bits): slave grant and response.
REQ-012 SHALL have port stall_cnt_o, output, NMASTER x 32 bits: per-master stall counter.

Function
REQ-013 SHALL decode each master address combinationally: the address hits a rule when start <= addr < end; on overlapping rules the lowest array index wins; an address hitting no rule targets the internal decode-error responder.
REQ-014 SHALL keep one round-robin pointer per slave, reset value 0; among the eligible requesters for that slave, the first index at or after the pointer (modulo NMASTER) is selected.
REQ-015 SHALL treat a master as eligible only when m_req_i=1 and the master has no pending transaction.
REQ-016 SHALL drive s_req_o[s]=1, with the selected master's payload, only when the slave has no outstanding transaction, or when s_rvalid_i[s]=1 in the same cycle.
REQ-017 SHALL assert m_gnt_o[m] in the same cycle as s_gnt_i[s], only for the selected master (zero-cycle grant path).
REQ-018 SHALL, on a slave handshake (s_req_o & s_gnt_i), set the slave-busy flag and the owner index, set the master-pending flag, and advance the pointer to (owner+1) mod NMASTER.
REQ-019 SHALL route s_rvalid_i[s] and s_rdata_i[s] combinationally to the owner, with m_err_o=0, and clear slave-busy and master-pending in the same cycle.
REQ-020 SHALL grant decode-error requests immediately when the master is eligible; exactly one cycle later it SHALL assert m_rvalid_o=1, m_err_o=1 and m_rdata_o=DECERR_DATA for that master, then clear its pending flag.
REQ-021 SHALL drive m_rdata_o to 0 whenever m_rvalid_o=0.
REQ-022 SHALL permit at most one outstanding transaction per master and per slave; a new grant in the same cycle as the completing rvalid SHALL be allowed.
REQ-023 SHALL never assert m_gnt_o or m_rvalid_o for a master when m_req_i was never asserted for the corresponding transaction.

Reset
REQ-024 SHALL, while rst_ni=0 at a clock edge, clear all pointers, busy flags, pending flags, owners and counters.
REQ-025 SHALL hold every output at 0 during reset.
REQ-026 SHALL, after a mid-operation reset, drop any s_rvalid_i for a pre-reset transaction: it is not routed to any master.

Configuration
REQ-027 SHALL, when EXT_XBAR_STALL_CNT_EN is defined, increment stall_cnt_o[m] each cycle with m_req_i[m]=1 and m_gnt_o[m]=0, saturating at 32'hFFFF_FFFF.
REQ-028 SHALL, when EXT_XBAR_STALL_CNT_EN is undefined, tie stall_cnt_o to 0 and instantiate no counter flops.

Verification
REQ-029 SHALL verify single read: master 2 reads 0xF000_0010; slave grants immediately and gives rvalid 3 cycles later with 0x1234_5678 -> m_rvalid_o[2]=1 carrying 0x1234_5678, err=0.
REQ-030 SHALL verify round robin: all 4 masters request continuously; slave grants every cycle with rvalid next cycle -> grant order 0,1,2,3,0.
REQ-031 SHALL verify decode error: master 1 accesses 0x0000_0000 -> granted the same cycle; next cycle m_err_o[1]=1 with rdata 0xBADA_CCE5; slave port untouched.
REQ-032 SHALL verify back-pressure: slave busy (rvalid delayed 5 cycles) while master 3 requests -> m_gnt_o[3] held 0 and, with the macro defined, stall_cnt_o[3] increments by 1 per stalled cycle.
REQ-033 SHALL verify reset mid-operation: rst_ni=0 for one cycle while master 0 is pending, then a late s_rvalid_i -> no m_rvalid_o; the pointer restarts at master 0.

Source files
------------

// File: rtl/ext_xbar_rr_arbiter.sv
// rtl/ext_xbar_rr_arbiter.sv - NMASTER x NSLAVE round-robin crossbar arbiter with decode-error responder
// Optional per-master stall counters are built when EXT_XBAR_STALL_CNT_EN is defined.
package ext_xbar_rr_arbiter_pkg;
  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] start_addr;
    logic [31:0] end_addr;
  } addr_rule_t;
endpackage

module ext_xbar_rr_arbiter
  import ext_xbar_rr_arbiter_pkg::*;
#(
  parameter int unsigned NMASTER = 4,
  parameter int unsigned NSLAVE = 1,
  parameter addr_rule_t [NSLAVE-1:0] ADDR_RULES =
    {NSLAVE{addr_rule_t'{idx: 32'd0, start_addr: 32'hF000_0000, end_addr: 32'hF010_0000}}},
  parameter logic [31:0] DECERR_DATA = 32'hBADA_CCE5
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NMASTER-1:0]        m_req_i,
  input  logic [NMASTER-1:0][31:0]  m_addr_i,
  input  logic [NMASTER-1:0]        m_we_i,
  input  logic [NMASTER-1:0][3:0]   m_be_i,
  input  logic [NMASTER-1:0][31:0]  m_wdata_i,
  output logic [NMASTER-1:0]        m_gnt_o,
  output logic [NMASTER-1:0]        m_rvalid_o,
  output logic [NMASTER-1:0][31:0]  m_rdata_o,
  output logic [NMASTER-1:0]        m_err_o,
  output logic [NSLAVE-1:0]         s_req_o,
  output logic [NSLAVE-1:0][31:0]   s_addr_o,
  output logic [NSLAVE-1:0]         s_we_o,
  output logic [NSLAVE-1:0][3:0]    s_be_o,
  output logic [NSLAVE-1:0][31:0]   s_wdata_o,
  input  logic [NSLAVE-1:0]         s_gnt_i,
  input  logic [NSLAVE-1:0]         s_rvalid_i,
  input  logic [NSLAVE-1:0][31:0]   s_rdata_i,
  output logic [NMASTER-1:0][31:0]  stall_cnt_o
);

  localparam int unsigned MW = (NMASTER > 1) ? $clog2(NMASTER) : 1;
  localparam int unsigned SW = (NSLAVE > 1) ? $clog2(NSLAVE) : 1;

  logic [NMASTER-1:0]          pending_q;
  logic [NMASTER-1:0]          derr_q;
  logic [NSLAVE-1:0]           busy_q;
  logic [NSLAVE-1:0][MW-1:0]   owner_q;
  logic [NSLAVE-1:0][MW-1:0]   ptr_q;

  logic [NMASTER-1:0]          hit;
  logic [NMASTER-1:0][SW-1:0]  tgt;
  logic [NMASTER-1:0]          rsp_valid;
  logic [NMASTER-1:0]          elig;
  logic [NMASTER-1:0]          gnt;
  logic [NSLAVE-1:0]           sel_valid;
  logic [NSLAVE-1:0][MW-1:0]   sel_idx;
  logic [NSLAVE-1:0]           s_hs;

  // Descending scan so the lowest-indexed matching rule is the one that sticks.
  always_comb begin
    hit = '0;
    tgt = '0;
    for (int m = 0; m < int'(NMASTER); m++) begin
      for (int r = int'(NSLAVE) - 1; r >= 0; r--) begin
        if (m_addr_i[m] >= ADDR_RULES[r].start_addr && m_addr_i[m] < ADDR_RULES[r].end_addr) begin
          hit[m] = (ADDR_RULES[r].idx < 32'(NSLAVE));
          tgt[m] = ADDR_RULES[r].idx[SW-1:0];
        end
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    m_rdata_o = '0;
    m_err_o   = '0;
    for (int s = 0; s < int'(NSLAVE); s++) begin
      if (busy_q[s] && s_rvalid_i[s]) begin
        rsp_valid[owner_q[s]] = 1'b1;
        m_rdata_o[owner_q[s]] = s_rdata_i[s];
      end
    end
    for (int m = 0; m < int'(NMASTER); m++) begin
      if (derr_q[m]) begin
        rsp_valid[m] = 1'b1;
        m_rdata_o[m] = DECERR_DATA;
        m_err_o[m]   = 1'b1;
      end
    end
    if (!rst_ni) begin
      rsp_valid = '0;
      m_rdata_o = '0;
      m_err_o   = '0;
    end
  end

  assign m_rvalid_o = rsp_valid;
  // A master whose response lands this cycle may already issue its next request.
  assign elig = m_req_i & ~(pending_q & ~rsp_valid);

  always_comb begin
    int c;
    c         = 0;
    sel_valid = '0;
    sel_idx   = '0;
    for (int s = 0; s < int'(NSLAVE); s++) begin
      for (int k = int'(NMASTER) - 1; k >= 0; k--) begin
        c = int'(ptr_q[s]) + k;
        if (c >= int'(NMASTER)) c = c - int'(NMASTER);
        if (elig[c] && hit[c] && tgt[c] == SW'(s)) begin
          sel_valid[s] = 1'b1;
          sel_idx[s]   = MW'(c);
        end
      end
    end
  end

  always_comb begin
    s_req_o   = '0;
    s_addr_o  = '0;
    s_we_o    = '0;
    s_be_o    = '0;
    s_wdata_o = '0;
    for (int s = 0; s < int'(NSLAVE); s++) begin
      if (rst_ni && sel_valid[s] && (!busy_q[s] || s_rvalid_i[s])) begin
        s_req_o[s]   = 1'b1;
        s_addr_o[s]  = m_addr_i[sel_idx[s]];
        s_we_o[s]    = m_we_i[sel_idx[s]];
        s_be_o[s]    = m_be_i[sel_idx[s]];
        s_wdata_o[s] = m_wdata_i[sel_idx[s]];
      end
    end
  end

  assign s_hs = s_req_o & s_gnt_i;

  always_comb begin
    gnt = '0;
    for (int m = 0; m < int'(NMASTER); m++) begin
      if (elig[m] && !hit[m]) gnt[m] = 1'b1;
    end
    for (int s = 0; s < int'(NSLAVE); s++) begin
      if (s_hs[s]) gnt[sel_idx[s]] = 1'b1;
    end
    if (!rst_ni) gnt = '0;
  end

  assign m_gnt_o = gnt;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '0;
      derr_q    <= '0;
      busy_q    <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
    end else begin
      for (int s = 0; s < int'(NSLAVE); s++) begin
        if (busy_q[s] && s_rvalid_i[s]) busy_q[s] <= 1'b0;
        if (s_hs[s]) begin
          busy_q[s]  <= 1'b1;
          owner_q[s] <= sel_idx[s];
          ptr_q[s]   <= (sel_idx[s] == MW'(NMASTER - 1)) ? '0 : sel_idx[s] + 1'b1;
        end
      end
      pending_q <= (pending_q & ~rsp_valid) | gnt;
      derr_q    <= gnt & ~hit;
    end
  end

`ifdef EXT_XBAR_STALL_CNT_EN
  logic [NMASTER-1:0][31:0] stall_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_q <= '0;
    end else begin
      for (int m = 0; m < int'(NMASTER); m++) begin
        if (m_req_i[m] && !gnt[m] && stall_q[m] != 32'hFFFF_FFFF) stall_q[m] <= stall_q[m] + 32'd1;
      end
    end
  end

  assign stall_cnt_o = rst_ni ? stall_q : '0;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
